// File: rtl/riscv_trace_buffer.sv
// Commit/memory trace capture: turns write-back and data-memory tap events into entries in a circular FIFO
// drained over valid/ready. Define TRACE_TIMESTAMP_EN to add a 16-bit cycle stamp in entry bits [58:43].
module riscv_trace_buffer #(
   parameter int DEPTH = 16,
`ifdef TRACE_TIMESTAMP_EN
   parameter int ENTRY_W = 59
`else
   parameter int ENTRY_W = 43
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    trace_en,
   input  logic                    reg_write_sig,
   input  logic [4:0]              reg_num,
   input  logic [31:0]             reg_data,
   input  logic                    wr,
   input  logic                    rd,
   input  logic [8:0]              addr,
   input  logic [31:0]             wr_data,
   input  logic [31:0]             rd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ENTRY_W-1:0]      out_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic [15:0]             dropped_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
   localparam logic [PW-1:0] DEPTH_M2 = PW'(DEPTH - 2);

   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic               reg_ev, mem_ev, pop;
   logic [1:0]         n_ev, n_push, n_drop;
   logic [42:0]        reg_entry, mem_entry;
   logic [ENTRY_W-1:0] first_entry, second_entry;
   logic [AW-1:0]      slot0, slot1;
   logic [16:0]        drop_sum;
   logic [15:0]        dropped_d;

   assign level     = wr_ptr_q - rd_ptr_q;
   assign out_valid = (level != '0);
   assign out_data  = mem[rd_ptr_q[AW-1:0]];
   assign pop       = out_valid & out_ready;

   always_comb begin
      reg_ev    = trace_en & reg_write_sig & (reg_num != 5'd0);
      // a simultaneous read and write records only the write
      mem_ev    = trace_en & (wr | rd);
      n_ev      = {1'b0, reg_ev} + {1'b0, mem_ev};
      reg_entry = {2'b01, 4'b0000, reg_num, reg_data};
      mem_entry = wr ? {2'b10, addr, wr_data} : {2'b11, addr, rd_data};

      // room is judged on start-of-cycle occupancy; a same-cycle pop does not help
      if (level <= DEPTH_M2) begin
         n_push = n_ev;
      end else if (level < DEPTH_L) begin
         n_push = (n_ev != 2'd0) ? 2'd1 : 2'd0;
      end else begin
         n_push = 2'd0;
      end
      n_drop    = n_ev - n_push;
      drop_sum  = {1'b0, dropped_cnt} + {15'd0, n_drop};
      dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      slot0 = wr_ptr_q[AW-1:0];
      slot1 = slot0 + 1'b1;
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [15:0] ts_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ts_q <= 16'd0;
      end else begin
         ts_q <= ts_q + 16'd1;
      end
   end

   assign first_entry  = {ts_q, reg_ev ? reg_entry : mem_entry};
   assign second_entry = {ts_q, mem_entry};
`else
   assign first_entry  = reg_ev ? reg_entry : mem_entry;
   assign second_entry = mem_entry;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         dropped_cnt <= 16'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_q + {{(PW-2){1'b0}}, n_push};
         rd_ptr_q    <= rd_ptr_q + {{(PW-1){1'b0}}, pop};
         dropped_cnt <= dropped_d;
      end
   end

   // storage is deliberately left uncleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         if (n_push != 2'd0) mem[slot0] <= first_entry;
         if (n_push == 2'd2) mem[slot1] <= second_entry;
      end
   end
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer: directed vector table, overflow/wrap/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_riscv_trace_buffer;
   localparam int DEPTH = 16;
`ifdef TRACE_TIMESTAMP_EN
   localparam int EW = 59;
`else
   localparam int EW = 43;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          trace_en, reg_write_sig, wr, rd, out_ready;
   logic [4:0]    reg_num;
   logic [31:0]   reg_data, wr_data, rd_data;
   logic [8:0]    addr;
   logic          out_valid;
   logic [EW-1:0] out_data;
   logic [4:0]    level;
   logic [15:0]   dropped_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [EW-1:0] mq[$];
   logic [15:0]   m_drop;
   logic [15:0]   m_ts;

   riscv_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en), .reg_write_sig(reg_write_sig),
      .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .level(level), .dropped_cnt(dropped_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        te, rws;
      logic [4:0]  rn;
      logic [31:0] rdat;
      logic        w, r;
      logic [8:0]  a;
      logic [31:0] wd, rdd;
      logic        rdy;
      logic        ev;
      logic [4:0]  el;
      logic [42:0] eh;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [8:0] idx, input logic [31:0] d);
`ifdef TRACE_TIMESTAMP_EN
      return {m_ts, k, idx, d};
`else
      return {k, idx, d};
`endif
   endfunction

   // Reference: events of this cycle, room from start-of-cycle size, pop from start-of-cycle state.
   task automatic model_step();
      logic [EW-1:0] ev[$];
      int sz;
      if (!reset) begin
         mq.delete();
         m_drop = 16'd0;
         m_ts   = 16'd0;
      end else begin
         sz = mq.size();
         if (trace_en && reg_write_sig && reg_num != 5'd0) ev.push_back(mk(2'b01, {4'd0, reg_num}, reg_data));
         if (trace_en && wr) ev.push_back(mk(2'b10, addr, wr_data));
         else if (trace_en && rd) ev.push_back(mk(2'b11, addr, rd_data));
         if (sz > 0 && out_ready) void'(mq.pop_front());
         for (int i = 0; i < ev.size(); i++) begin
            if (sz + i < DEPTH) mq.push_back(ev[i]);
            else if (m_drop != 16'hFFFF) m_drop++;
         end
         m_ts++;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      trace_en = 1'b1; reg_write_sig = 1'b0; reg_num = 5'd0; reg_data = 32'd0;
      wr = 1'b0; rd = 1'b0; addr = 9'd0; wr_data = 32'd0; rd_data = 32'd0; out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic check_model(input string nm);
      chk({nm, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
      chk({nm, ".level"}, 64'(level), 64'(mq.size()));
      chk({nm, ".drop"}, 64'(dropped_cnt), 64'(m_drop));
      if (mq.size() != 0) chk({nm, ".data"}, 64'(out_data), 64'(mq[0]));
   endtask

   initial begin
      tv[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b0, 1'b1, 5'd1, {2'b01, 9'd5, 32'hDEADBEEF}};
      tv[1]  = '{1'b1, 1'b1, 5'd0,  32'h99,       1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b0, 1'b1, 5'd1, {2'b01, 9'd5, 32'hDEADBEEF}};
      tv[2]  = '{1'b0, 1'b1, 5'd7,  32'h77,       1'b1, 1'b0, 9'h010, 32'h88,   32'h0,    1'b0, 1'b1, 5'd1, {2'b01, 9'd5, 32'hDEADBEEF}};
      tv[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 9'h0AA, 32'h1234, 32'h5678, 1'b0, 1'b1, 5'd2, {2'b01, 9'd5, 32'hDEADBEEF}};
      tv[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b1, 1'b1, 5'd1, {2'b10, 9'h0AA, 32'h1234}};
      tv[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b1, 1'b0, 5'd0, 43'd0};
      tv[6]  = '{1'b1, 1'b1, 5'd3,  32'h11,       1'b1, 1'b0, 9'h1F0, 32'h22,   32'h0,    1'b0, 1'b1, 5'd2, {2'b01, 9'd3, 32'h11}};
      tv[7]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b1, 1'b1, 5'd1, {2'b10, 9'h1F0, 32'h22}};
      tv[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 9'h033, 32'h0,    32'hCAFE, 1'b1, 1'b1, 5'd1, {2'b11, 9'h033, 32'hCAFE}};
      tv[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b1, 1'b0, 5'd0, 43'd0};
      tv[10] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b1, 1'b1, 5'd1, {2'b01, 9'd31, 32'hFFFFFFFF}};
      tv[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 9'h000, 32'h0,    32'h0,    1'b1, 1'b0, 5'd0, 43'd0};

      reset = 1'b0;
      do_reset();
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.level", 64'(level), 64'd0);
      chk("rst.drop", 64'(dropped_cnt), 64'd0);

      // directed table
      for (int i = 0; i < 12; i++) begin
         trace_en = tv[i].te; reg_write_sig = tv[i].rws; reg_num = tv[i].rn; reg_data = tv[i].rdat;
         wr = tv[i].w; rd = tv[i].r; addr = tv[i].a; wr_data = tv[i].wd; rd_data = tv[i].rdd;
         out_ready = tv[i].rdy;
         cyc();
         chk($sformatf("tv%0d.valid", i), 64'(out_valid), 64'(tv[i].ev));
         chk($sformatf("tv%0d.level", i), 64'(level), 64'(tv[i].el));
         chk($sformatf("tv%0d.drop", i), 64'(dropped_cnt), 64'd0);
         if (tv[i].ev) chk($sformatf("tv%0d.head", i), 64'(out_data[42:0]), 64'(tv[i].eh));
      end

      // overflow: 15 singles then a dual event with one free slot
      do_reset();
      for (int i = 0; i < 15; i++) begin
         idle(); wr = 1'b1; addr = 9'(i); wr_data = 32'(i);
         cyc();
      end
      idle(); reg_write_sig = 1'b1; reg_num = 5'd9; reg_data = 32'hAA;
      wr = 1'b1; addr = 9'h100; wr_data = 32'hBB;
      cyc();
      chk("ovf.level", 64'(level), 64'd16);
      chk("ovf.drop", 64'(dropped_cnt), 64'd1);
      for (int i = 0; i < 100; i++) cyc();
      chk("ovf.drop201", 64'(dropped_cnt), 64'd201);
      for (int i = 0; i < 34900; i++) cyc();
      chk("ovf.sat", 64'(dropped_cnt), 64'hFFFF);
      idle(); out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k < 15) chk($sformatf("ovf.pop%0d", k), 64'(out_data[42:0]), 64'({2'b10, 9'(k), 32'(k)}));
         else        chk("ovf.pop15", 64'(out_data[42:0]), 64'({2'b01, 9'd9, 32'hAA}));
         cyc();
      end
      chk("ovf.empty", 64'(level), 64'd0);
      chk("ovf.satkeep", 64'(dropped_cnt), 64'hFFFF);

      // wrap with concurrent push and pop while full
      do_reset();
      for (int i = 0; i < 16; i++) begin
         idle(); wr = 1'b1; addr = 9'(i); wr_data = 32'h100 + 32'(i);
         cyc();
      end
      chk("wrap.full", 64'(level), 64'd16);
      for (int j = 0; j < 40; j++) begin
         idle(); out_ready = 1'b1; wr = 1'b1; addr = 9'h80 + 9'(j); wr_data = 32'h200 + 32'(j);
         cyc();
         check_model($sformatf("wrap%0d", j));
      end
      chk("wrap.drop", 64'(dropped_cnt), 64'd1);
      chk("wrap.level", 64'(level), 64'd15);

      // reset mid-run at level 9
      idle(); out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      chk("mid.level9", 64'(level), 64'd9);
      reg_write_sig = 1'b1; reg_num = 5'd6; reg_data = 32'h66;
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      chk("mid.valid", 64'(out_valid), 64'd0);
      chk("mid.level", 64'(level), 64'd0);
      chk("mid.drop", 64'(dropped_cnt), 64'd0);
      idle();
      for (int i = 0; i < 3; i++) cyc();
      reg_write_sig = 1'b1; reg_num = 5'd4; reg_data = 32'h44;
      cyc();
      check_model("mid.post");
`ifdef TRACE_TIMESTAMP_EN
      chk("mid.stamp", 64'(out_data[58:43]), 64'd3);
`endif

      // randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         trace_en      = ($urandom_range(0, 9) != 0);
         reg_write_sig = 1'($urandom_range(0, 1));
         reg_num       = 5'($urandom_range(0, 31));
         reg_data      = $urandom;
         wr            = 1'($urandom_range(0, 1));
         rd            = 1'($urandom_range(0, 1));
         addr          = 9'($urandom_range(0, 511));
         wr_data       = $urandom;
         rd_data       = $urandom;
         out_ready     = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cyc();
         check_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
